// File: rtl/bcd_subtractor_serial_if.sv
// ============================================================================
//  Module   : bcd_subtractor_serial_if
//  Brief    : Handshake and operand bundle for the digit-serial BCD subtractor.
//             The err signal exists only when BCD_SUB_DIGIT_CHECK_EN is defined.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface bcd_subtractor_serial_if #(
    parameter int DIGITS = 4
);
    logic                  start;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  bin;
    logic                  ready;
    logic                  done;
    logic [4*DIGITS-1:0]   diff;
    logic                  bout;
`ifdef BCD_SUB_DIGIT_CHECK_EN
    logic                  err;
`endif

    modport master (
        output start, a, b, bin,
        input  ready, done, diff, bout
`ifdef BCD_SUB_DIGIT_CHECK_EN
        , input err
`endif
    );

    modport slave (
        input  start, a, b, bin,
        output ready, done, diff, bout
`ifdef BCD_SUB_DIGIT_CHECK_EN
        , output err
`endif
    );
endinterface

`default_nettype wire

// File: rtl/bcd_subtractor_serial.sv
// ============================================================================
//  Module   : bcd_subtractor_serial
//  Brief    : Digit-serial ten's-complement BCD subtractor, diff = a - b - bin,
//             one digit per clock, LSD first. Optional macro:
//             BCD_SUB_DIGIT_CHECK_EN adds err (non-BCD operand digit flag).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module bcd_subtractor_serial #(
    parameter int DIGITS = 4
) (
    input  wire logic                      clk,
    input  wire logic                      rst,
    bcd_subtractor_serial_if.slave         bus
);

    localparam int c_W     = 4 * DIGITS;
    localparam int c_IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DIGITS - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CALC = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]          state_q,  state_d;
    logic [c_IDX_W-1:0]  idx_q,    idx_d;
    logic                borrow_q, borrow_d;
    logic [c_W-1:0]      a_q,      a_d;
    logic [c_W-1:0]      b_q,      b_d;
    logic [c_W-1:0]      work_q,   work_d;
    logic [c_W-1:0]      diff_q,   diff_d;
    logic                bout_q,   bout_d;
`ifdef BCD_SUB_DIGIT_CHECK_EN
    logic                err_q,    err_d;
    logic                w_bad;
`endif

    logic [3:0]          w_a_dig;
    logic [3:0]          w_b_dig;
    logic [4:0]          w_t;
    logic                w_neg;
    logic [3:0]          w_digit;
    logic                w_ready;
    logic                w_done;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= c_ST_IDLE;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            work_q   <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
`ifdef BCD_SUB_DIGIT_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            borrow_q <= borrow_d;
            a_q      <= a_d;
            b_q      <= b_d;
            work_q   <= work_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
`ifdef BCD_SUB_DIGIT_CHECK_EN
            err_q    <= err_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE: if (bus.start)            state_d = c_ST_CALC;
            c_ST_CALC: if (idx_q == c_LAST_IDX)  state_d = c_ST_DONE;
            c_ST_DONE:                           state_d = c_ST_IDLE;
            default:                             state_d = c_ST_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        w_ready = (state_q == c_ST_IDLE);
        w_done  = (state_q == c_ST_DONE);
    end

    // One digit slice: negative difference wraps by +10 and raises the borrow
    always_comb begin
        w_a_dig = a_q[{idx_q, 2'b00} +: 4];
        w_b_dig = b_q[{idx_q, 2'b00} +: 4];
        w_t     = {1'b0, w_a_dig} - {1'b0, w_b_dig} - {4'b0000, borrow_q};
        w_neg   = w_t[4];
        w_digit = w_neg ? (w_t[3:0] + 4'd10) : w_t[3:0];
    end

`ifdef BCD_SUB_DIGIT_CHECK_EN
    always_comb begin
        w_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if ((a_q[4*i +: 4] > 4'd9) || (b_q[4*i +: 4] > 4'd9)) begin
                w_bad = 1'b1;
            end
        end
    end
`endif

    // Datapath register updates
    always_comb begin
        idx_d    = idx_q;
        borrow_d = borrow_q;
        a_d      = a_q;
        b_d      = b_q;
        work_d   = work_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
`ifdef BCD_SUB_DIGIT_CHECK_EN
        err_d    = err_q;
`endif
        case (state_q)
            c_ST_IDLE: begin
                if (bus.start) begin
                    a_d      = bus.a;
                    b_d      = bus.b;
                    borrow_d = bus.bin;
                    idx_d    = '0;
                    work_d   = '0;
                end
            end
            c_ST_CALC: begin
                work_d[{idx_q, 2'b00} +: 4] = w_digit;
                borrow_d = w_neg;
                idx_d    = idx_q + c_IDX_W'(1);
                // Results become visible only on the final digit's edge
                if (idx_q == c_LAST_IDX) begin
                    diff_d = work_d;
                    bout_d = w_neg;
`ifdef BCD_SUB_DIGIT_CHECK_EN
                    err_d  = w_bad;
`endif
                end
            end
            default: ;
        endcase
    end

    assign bus.ready = w_ready;
    assign bus.done  = w_done;
    assign bus.diff  = diff_q;
    assign bus.bout  = bout_q;
`ifdef BCD_SUB_DIGIT_CHECK_EN
    assign bus.err   = err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bcd_subtractor_serial.sv
// ============================================================================
//  Module   : tb_bcd_subtractor_serial
//  Brief    : Randomized and directed bench for bcd_subtractor_serial against
//             a decimal-arithmetic reference model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bcd_subtractor_serial;

    localparam int D = 4;
    localparam int W = 4 * D;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bcd_subtractor_serial_if #(.DIGITS(D)) bus ();

    bcd_subtractor_serial #(.DIGITS(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Decimal reference: real subtraction for BCD operands, digit rule otherwise
    function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic bin);
        longint    av = 0;
        longint    bv = 0;
        longint    p  = 1;
        longint    d;
        logic      nonbcd = 1'b0;
        logic [W-1:0] r = '0;
        int        t;
        int        brw;
        for (int i = 0; i < D; i++) begin
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) nonbcd = 1'b1;
            av += longint'(a[4*i +: 4]) * p;
            bv += longint'(b[4*i +: 4]) * p;
            p  *= 10;
        end
        if (!nonbcd) begin
            d = av - bv - longint'(bin);
            if (d < 0) begin d += p; brw = 1; end else brw = 0;
            for (int i = 0; i < D; i++) begin
                r[4*i +: 4] = 4'(d % 10);
                d = d / 10;
            end
        end else begin
            brw = int'(bin);
            for (int i = 0; i < D; i++) begin
                t = int'(a[4*i +: 4]) - int'(b[4*i +: 4]) - brw;
                if (t < 0) begin t += 10; brw = 1; end else brw = 0;
                r[4*i +: 4] = 4'(t);
            end
        end
        return {1'(brw), r};
    endfunction

    function automatic logic has_bad(input logic [W-1:0] a, input logic [W-1:0] b);
        logic bad = 1'b0;
        for (int i = 0; i < D; i++)
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad = 1'b1;
        return bad;
    endfunction

    // Cycle-level model: el counts edges since acceptance, -1 when idle
    int         el      = -1;
    logic       acc_nxt = 1'b0;
    logic [W:0] cur     = '0;
    logic [W:0] vis     = '0;
    logic       cur_bad = 1'b0;
    logic       vis_bad = 1'b0;
    int         cyc     = 0;
    int         done_t[$];

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            el = -1; acc_nxt = 1'b0; vis = '0; vis_bad = 1'b0;
        end else if (acc_nxt) begin
            el = 0; acc_nxt = 1'b0;
        end else if (el >= 0) begin
            el++;
            if (el == D) begin
                vis = cur; vis_bad = cur_bad;
            end else if (el == D + 1) begin
                el = -1;
            end
        end
        chk("ready", 32'(bus.ready), 32'(el < 0));
        chk("done",  32'(bus.done),  32'(el == D));
        chk("diff",  32'(bus.diff),  32'(vis[W-1:0]));
        chk("bout",  32'(bus.bout),  32'(vis[W]));
`ifdef BCD_SUB_DIGIT_CHECK_EN
        chk("err",   32'(bus.err),   32'(vis_bad));
`endif
        if (bus.done === 1'b1) done_t.push_back(cyc);
        if (!rst && el < 0 && bus.start) begin
            acc_nxt = 1'b1;
            cur     = ref_sub(bus.a, bus.b, bus.bin);
            cur_bad = has_bad(bus.a, bus.b);
        end
    end

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] v;
        for (int i = 0; i < D; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    // Issue one operation and wait for its done pulse, scrambling inputs meanwhile
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        int k = 0;
        while (bus.ready !== 1'b1 && k < 30) begin @(posedge clk); #1; k++; end
        chk("ready_timeout", 32'(bus.ready), 32'd1);
        bus.a = a; bus.b = b; bus.bin = bin; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        k = 0;
        while (bus.done !== 1'b1 && k < 30) begin
            bus.a = W'($urandom); bus.b = W'($urandom); bus.bin = 1'($urandom);
            @(posedge clk); #1; k++;
        end
        chk("latency", 32'(k), 32'(D));
    endtask

    task automatic op_lit(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                          input logic [W-1:0] ed, input logic eb);
        do_op(a, b, bin);
        chk("lit_diff", 32'(bus.diff), 32'(ed));
        chk("lit_bout", 32'(bus.bout), 32'(eb));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("ref_pin0", 32'(ref_sub(16'h5353, 16'h5158, 1'b1)), 32'h0_0194);
        chk("ref_pin1", 32'(ref_sub(16'h1423, 16'h2683, 1'b0)), 32'h1_8740);
        chk("ref_pin2", 32'(ref_sub(16'h0000, 16'h0001, 1'b0)), 32'h1_9999);

        op_lit(16'h5353, 16'h5158, 1'b1, 16'h0194, 1'b0);
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(bus.done), 32'd0);
        chk("ready_returns", 32'(bus.ready), 32'd1);
        op_lit(16'h1423, 16'h2683, 1'b0, 16'h8740, 1'b1);
        op_lit(16'h1823, 16'h2613, 1'b1, 16'h9209, 1'b1);
        op_lit(16'h0000, 16'h0001, 1'b0, 16'h9999, 1'b1);
        op_lit(16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1);
        op_lit(16'h9999, 16'h0000, 1'b0, 16'h9999, 1'b0);

        // start pulsed during CALC must be ignored
        @(posedge clk); #1;
        bus.a = 16'h4352; bus.b = 16'h0013; bus.bin = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.a = 16'h1111; bus.b = 16'h0000;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.a = 16'h7777; bus.b = 16'h2222; bus.bin = 1'b1;
        k = 0;
        while (bus.done !== 1'b1 && k < 30) begin @(posedge clk); #1; k++; end
        chk("proto_diff", 32'(bus.diff), 32'h4339);
        chk("proto_bout", 32'(bus.bout), 32'd0);

        // start held high: one result every DIGITS+2 cycles
        repeat (3) @(posedge clk); #1;
        done_t.delete();
        bus.a = 16'h8000; bus.b = 16'h0001; bus.bin = 1'b0; bus.start = 1'b1;
        k = 0;
        while (done_t.size() < 3 && k < 60) begin @(posedge clk); #1; k++; end
        bus.start = 1'b0;
        chk("b2b_count", 32'(done_t.size() >= 3), 32'd1);
        if (done_t.size() >= 3) begin
            chk("b2b_gap0", 32'(done_t[1] - done_t[0]), 32'd6);
            chk("b2b_gap1", 32'(done_t[2] - done_t[1]), 32'd6);
        end
        chk("b2b_diff", 32'(bus.diff), 32'h7999);
        repeat (10) @(posedge clk); #1;

        // reset in the 2nd CALC cycle aborts with nothing visible
        bus.a = 16'h2468; bus.b = 16'h1357; bus.bin = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_done",  32'(bus.done),  32'd0);
        chk("rst_diff",  32'(bus.diff),  32'd0);
        chk("rst_bout",  32'(bus.bout),  32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (D + 3) @(posedge clk); #1;
        op_lit(16'h2468, 16'h1357, 1'b0, 16'h1111, 1'b0);

`ifdef BCD_SUB_DIGIT_CHECK_EN
        do_op(16'h1A23, 16'h0001, 1'b0);
        chk("err_set", 32'(bus.err), 32'd1);
        op_lit(16'h0002, 16'h0001, 1'b0, 16'h0001, 1'b0);
        chk("err_clr", 32'(bus.err), 32'd0);
`endif

        for (int n = 0; n < 60; n++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            do_op(rand_bcd(), rand_bcd(), 1'($urandom));
        end

        repeat (4) @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
